// File: rtl/tetris_game_ctrl.sv
// Tetris game sequencer: owns the active piece position/rotation, turns key
// pulses and a gravity tick into candidate moves, checks them through the
// external collision checker, locks pieces, scans for full rows and spawns.
// Optional feature macro: TETRIS_HARD_DROP_EN (down held on two consecutive
// cycles while READY drops the piece until it collides or reaches the floor).
module tetris_game_ctrl #(
    parameter int ROWS     = 20,
    parameter int COLS     = 20,
    parameter int X_W      = 5,
    parameter int Y_W      = 5,
    parameter int SPAWN_X  = 8,
    parameter int DROP_DIV = 50000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            left_i,
    input  logic            right_i,
    input  logic            down_i,
    input  logic            ro_i,
    input  logic            check_ack_i,
    input  logic            collide_i,
    input  logic [ROWS-1:0] row_full_i,
    output logic [X_W-1:0]  pos_x_o,
    output logic [Y_W-1:0]  pos_y_o,
    output logic [1:0]      rot_o,
    output logic [X_W-1:0]  cand_x_o,
    output logic [Y_W-1:0]  cand_y_o,
    output logic [1:0]      cand_rot_o,
    output logic            check_req_o,
    output logic            next_block_o,
    output logic            bg_refresh_o,
    output logic            field_clear_o,
    output logic            clr_en_o,
    output logic [Y_W-1:0]  clr_row_o,
    output logic            score_plus_o,
    output logic [7:0]      lines_o,
    output logic            gameover_o
);

    localparam int CNT_W = (DROP_DIV > 2) ? $clog2(DROP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DROP_DIV - 1);
    localparam logic [X_W-1:0]   LAST_X  = X_W'(COLS - 1);
    localparam logic [Y_W-1:0]   LAST_Y  = Y_W'(ROWS - 1);
    localparam logic [X_W-1:0]   SPAWN_COL = X_W'(SPAWN_X);

    typedef enum logic [2:0] {
        S_IDLE, S_SPAWN, S_SPAWN_CHK, S_READY, S_MOVE_CHK, S_LOCK, S_CLEAR, S_OVER
    } state_e;

    typedef enum logic [2:0] {
        MV_ROT, MV_LEFT, MV_RIGHT, MV_DOWN, MV_GRAV
    } move_e;

    state_e           state_q, state_d;
    move_e            mv_q, mv_d;
    logic [X_W-1:0]   pos_x_q, pos_x_d, cand_x_q, cand_x_d;
    logic [Y_W-1:0]   pos_y_q, pos_y_d, cand_y_q, cand_y_d;
    logic [1:0]       rot_q, rot_d, cand_rot_q, cand_rot_d;
    logic             check_req_q, check_req_d;
    logic             next_block_q, next_block_d;
    logic             bg_refresh_q, bg_refresh_d;
    logic             field_clear_q, field_clear_d;
    logic             clr_en_q, clr_en_d;
    logic [Y_W-1:0]   clr_row_q, clr_row_d;
    logic             score_plus_q, score_plus_d;
    logic [7:0]       lines_q, lines_d;
    logic             gameover_q, gameover_d;
    logic [Y_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0] grav_cnt_q, grav_cnt_d;
    logic             grav_pend_q, grav_pend_d;
    logic             grav_tick;
    logic             issue;
`ifdef TETRIS_HARD_DROP_EN
    logic             down_q;
    logic             hard_q, hard_d;
`endif

    // Next-state and output decode for the game sequencer.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        mv_d          = mv_q;
        pos_x_d       = pos_x_q;
        pos_y_d       = pos_y_q;
        rot_d         = rot_q;
        cand_x_d      = cand_x_q;
        cand_y_d      = cand_y_q;
        cand_rot_d    = cand_rot_q;
        check_req_d   = 1'b0;
        next_block_d  = 1'b0;
        bg_refresh_d  = 1'b0;
        field_clear_d = 1'b0;
        clr_en_d      = 1'b0;
        clr_row_d     = clr_row_q;
        score_plus_d  = 1'b0;
        lines_d       = lines_q;
        gameover_d    = gameover_q;
        idx_d         = idx_q;
        grav_cnt_d    = grav_cnt_q;
        grav_pend_d   = grav_pend_q;
        grav_tick     = 1'b0;
        issue         = 1'b0;
`ifdef TETRIS_HARD_DROP_EN
        hard_d        = hard_q;
`endif

        // Gravity only advances while a piece is in play.
        if (state_q == S_READY || state_q == S_MOVE_CHK) begin
            if (grav_cnt_q == CNT_MAX) begin
                grav_cnt_d = '0;
                grav_tick  = 1'b1;
            end else begin
                grav_cnt_d = grav_cnt_q + CNT_W'(1);
            end
        end
        if (grav_tick) grav_pend_d = 1'b1;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_i) begin
                    field_clear_d = 1'b1;
                    lines_d       = '0;
                    gameover_d    = 1'b0;
                    // A new game restarts the gravity phase.
                    grav_cnt_d    = '0;
                    grav_pend_d   = 1'b0;
                    state_d       = S_SPAWN;
                end
            end

            S_SPAWN: begin
                next_block_d = 1'b1;
                cand_x_d     = SPAWN_COL;
                cand_y_d     = '0;
                cand_rot_d   = '0;
                check_req_d  = 1'b1;
                state_d      = S_SPAWN_CHK;
            end

            S_SPAWN_CHK: begin
                if (check_ack_i) begin
                    if (collide_i) begin
                        gameover_d = 1'b1;
                        state_d    = S_OVER;
                    end else begin
                        pos_x_d = cand_x_q;
                        pos_y_d = cand_y_q;
                        rot_d   = cand_rot_q;
                        state_d = S_READY;
                    end
                end
            end

            S_READY: begin
                // Priority: ro > left > right > down > pending gravity.
                if (ro_i) begin
                    cand_x_d = pos_x_q; cand_y_d = pos_y_q; cand_rot_d = rot_q + 2'd1;
                    mv_d = MV_ROT; issue = 1'b1;
                end else if (left_i) begin
                    if (pos_x_q != '0) begin
                        cand_x_d = pos_x_q - X_W'(1); cand_y_d = pos_y_q; cand_rot_d = rot_q;
                        mv_d = MV_LEFT; issue = 1'b1;
                    end
                end else if (right_i) begin
                    if (pos_x_q != LAST_X) begin
                        cand_x_d = pos_x_q + X_W'(1); cand_y_d = pos_y_q; cand_rot_d = rot_q;
                        mv_d = MV_RIGHT; issue = 1'b1;
                    end
                end else if (down_i) begin
                    if (pos_y_q == LAST_Y) begin
                        state_d = S_LOCK;
                    end else begin
                        cand_x_d = pos_x_q; cand_y_d = pos_y_q + Y_W'(1); cand_rot_d = rot_q;
                        mv_d = MV_DOWN; issue = 1'b1;
`ifdef TETRIS_HARD_DROP_EN
                        hard_d = down_q;
`endif
                    end
                end else if (grav_pend_q) begin
                    if (pos_y_q == LAST_Y) begin
                        grav_pend_d = grav_tick;
                        state_d     = S_LOCK;
                    end else begin
                        cand_x_d = pos_x_q; cand_y_d = pos_y_q + Y_W'(1); cand_rot_d = rot_q;
                        mv_d = MV_GRAV; issue = 1'b1;
                    end
                end
                if (issue) begin
                    check_req_d = 1'b1;
                    state_d     = S_MOVE_CHK;
                end
            end

            S_MOVE_CHK: begin
                if (check_ack_i) begin
`ifdef TETRIS_HARD_DROP_EN
                    if (hard_q) begin
                        if (collide_i) begin
                            hard_d  = 1'b0;
                            state_d = S_LOCK;
                        end else begin
                            pos_y_d = cand_y_q;
                            if (cand_y_q == LAST_Y) begin
                                hard_d  = 1'b0;
                                state_d = S_LOCK;
                            end else begin
                                cand_y_d    = cand_y_q + Y_W'(1);
                                check_req_d = 1'b1;
                            end
                        end
                    end else
`endif
                    begin
                        if (!collide_i) begin
                            pos_x_d = cand_x_q;
                            pos_y_d = cand_y_q;
                            rot_d   = cand_rot_q;
                            state_d = S_READY;
                        end else if (mv_q == MV_DOWN || mv_q == MV_GRAV) begin
                            state_d = S_LOCK;
                        end else begin
                            state_d = S_READY;
                        end
                        // A tick landing on the resolve cycle stays pending.
                        if (mv_q == MV_GRAV) grav_pend_d = grav_tick;
                    end
                end
            end

            S_LOCK: begin
                bg_refresh_d = 1'b1;
                idx_d        = LAST_Y;
                state_d      = S_CLEAR;
            end

            S_CLEAR: begin
                // A cleared row is re-examined because the rows above shift into it.
                if (row_full_i[idx_q]) begin
                    clr_en_d     = 1'b1;
                    clr_row_d    = idx_q;
                    score_plus_d = 1'b1;
                    if (lines_q != 8'hFF) lines_d = lines_q + 8'd1;
                end else if (idx_q == '0) begin
                    state_d = S_SPAWN;
                end else begin
                    idx_d = idx_q - Y_W'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset clears every output and the gravity timer.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            mv_q          <= MV_ROT;
            pos_x_q       <= '0;
            pos_y_q       <= '0;
            rot_q         <= '0;
            cand_x_q      <= '0;
            cand_y_q      <= '0;
            cand_rot_q    <= '0;
            check_req_q   <= 1'b0;
            next_block_q  <= 1'b0;
            bg_refresh_q  <= 1'b0;
            field_clear_q <= 1'b0;
            clr_en_q      <= 1'b0;
            clr_row_q     <= '0;
            score_plus_q  <= 1'b0;
            lines_q       <= '0;
            gameover_q    <= 1'b0;
            idx_q         <= '0;
            grav_cnt_q    <= '0;
            grav_pend_q   <= 1'b0;
`ifdef TETRIS_HARD_DROP_EN
            down_q        <= 1'b0;
            hard_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            mv_q          <= mv_d;
            pos_x_q       <= pos_x_d;
            pos_y_q       <= pos_y_d;
            rot_q         <= rot_d;
            cand_x_q      <= cand_x_d;
            cand_y_q      <= cand_y_d;
            cand_rot_q    <= cand_rot_d;
            check_req_q   <= check_req_d;
            next_block_q  <= next_block_d;
            bg_refresh_q  <= bg_refresh_d;
            field_clear_q <= field_clear_d;
            clr_en_q      <= clr_en_d;
            clr_row_q     <= clr_row_d;
            score_plus_q  <= score_plus_d;
            lines_q       <= lines_d;
            gameover_q    <= gameover_d;
            idx_q         <= idx_d;
            grav_cnt_q    <= grav_cnt_d;
            grav_pend_q   <= grav_pend_d;
`ifdef TETRIS_HARD_DROP_EN
            down_q        <= down_i;
            hard_q        <= hard_d;
`endif
        end
    end

    assign pos_x_o       = pos_x_q;
    assign pos_y_o       = pos_y_q;
    assign rot_o         = rot_q;
    assign cand_x_o      = cand_x_q;
    assign cand_y_o      = cand_y_q;
    assign cand_rot_o    = cand_rot_q;
    assign check_req_o   = check_req_q;
    assign next_block_o  = next_block_q;
    assign bg_refresh_o  = bg_refresh_q;
    assign field_clear_o = field_clear_q;
    assign clr_en_o      = clr_en_q;
    assign clr_row_o     = clr_row_q;
    assign score_plus_o  = score_plus_q;
    assign lines_o       = lines_q;
    assign gameover_o    = gameover_q;

endmodule

// File: tb/tb_tetris_game_ctrl.sv
// Self-checking bench for tetris_game_ctrl: a table of key moves plus hand-written
// sequences for gravity, lock/row-clear, game over, wall guards and mid-check reset.
// A checker model answers every check_req one cycle later and pops the expected
// candidate from a scoreboard queue.
module tb_tetris_game_ctrl;

    localparam int DROP = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, left = 1'b0, right = 1'b0, down = 1'b0, ro = 1'b0;
    logic        check_ack = 1'b0, collide = 1'b0;
    logic [19:0] row_full = '0;
    logic [4:0]  pos_x, pos_y, cand_x, cand_y, clr_row;
    logic [1:0]  rot, cand_rot;
    logic        check_req, next_block, bg_refresh, field_clear, clr_en, score_plus, gameover;
    logic [7:0]  lines;

    tetris_game_ctrl #(.ROWS(20), .COLS(20), .X_W(5), .Y_W(5), .SPAWN_X(8), .DROP_DIV(DROP)) dut (
        .clk(clk), .rst(rst), .start_i(start), .left_i(left), .right_i(right),
        .down_i(down), .ro_i(ro), .check_ack_i(check_ack), .collide_i(collide),
        .row_full_i(row_full), .pos_x_o(pos_x), .pos_y_o(pos_y), .rot_o(rot),
        .cand_x_o(cand_x), .cand_y_o(cand_y), .cand_rot_o(cand_rot),
        .check_req_o(check_req), .next_block_o(next_block), .bg_refresh_o(bg_refresh),
        .field_clear_o(field_clear), .clr_en_o(clr_en), .clr_row_o(clr_row),
        .score_plus_o(score_plus), .lines_o(lines), .gameover_o(gameover)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] K_RO = 4'b1000, K_LEFT = 4'b0100, K_RIGHT = 4'b0010, K_DOWN = 4'b0001;

    typedef struct { int x; int y; int r; } cand_t;
    typedef struct {
        logic [3:0] key;
        logic       coll;
        int cx, cy, cr;
        int px, py, pr;
    } vec_t;

    cand_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    logic  collide_val = 1'b0;
    logic  ack_next = 1'b0, coll_next = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_cand(input int x, input int y, input int r);
        cand_t c;
        c.x = x; c.y = y; c.r = r;
        exp_q.push_back(c);
    endtask

    // Collision checker model: acks one cycle after each request and compares
    // the presented candidate against the scoreboard.
    always @(negedge clk) begin
        cand_t e;
        check_ack = ack_next;
        collide   = ack_next & coll_next;
        ack_next  = rst ? 1'b0 : check_req;
        coll_next = collide_val;
        if (check_req === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected check_req", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sb cand_x", int'(cand_x), e.x);
                check("sb cand_y", int'(cand_y), e.y);
                check("sb cand_rot", int'(cand_rot), e.r);
            end
        end
    end

    task automatic check_pos(input string nm, input int px, input int py, input int pr);
        check({nm, " pos_x"}, int'(pos_x), px);
        check({nm, " pos_y"}, int'(pos_y), py);
        check({nm, " rot"}, int'(rot), pr);
    endtask

    // Starts a game from IDLE/OVER; returns on the cycle the spawn result is visible.
    task automatic start_game(input logic coll);
        push_cand(8, 0, 0);
        collide_val = coll;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("field_clear", int'(field_clear), 1);
        check("lines after start", int'(lines), 0);
        check("gameover after start", int'(gameover), 0);
        @(negedge clk);
        check("next_block", int'(next_block), 1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic do_move(input logic [3:0] k, input logic coll, input int cx, input int cy,
                           input int cr, input int px, input int py, input int pr, input string nm);
        push_cand(cx, cy, cr);
        collide_val = coll;
        {ro, left, right, down} = k;
        @(negedge clk);
        {ro, left, right, down} = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        check_pos(nm, px, py, pr);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{K_RIGHT,          1'b0, 9, 0, 1, 9, 0, 1};
        vecs[0] = '{K_RIGHT,          1'b0, 9, 0, 0, 9, 0, 0};
        vecs[1] = '{K_RO,             1'b0, 9, 0, 1, 9, 0, 1};
        vecs[2] = '{K_LEFT,           1'b1, 8, 0, 1, 9, 0, 1};
        vecs[3] = '{K_DOWN,           1'b0, 9, 1, 1, 9, 1, 1};
        vecs[4] = '{K_RO,             1'b1, 9, 1, 2, 9, 1, 1};
        vecs[5] = '{K_RO,             1'b0, 9, 1, 2, 9, 1, 2};
        vecs[6] = '{K_LEFT,           1'b0, 8, 1, 2, 8, 1, 2};
        vecs[7] = '{K_RO | K_LEFT,    1'b0, 8, 1, 3, 8, 1, 3};
        vecs[8] = '{K_LEFT | K_RIGHT | K_DOWN, 1'b0, 7, 1, 3, 7, 1, 3};
        vecs[9] = '{K_RO,             1'b0, 7, 1, 0, 7, 1, 0};

        // Reset state.
        repeat (3) @(negedge clk);
        check_pos("reset", 0, 0, 0);
        check("reset check_req", int'(check_req), 0);
        check("reset lines", int'(lines), 0);
        check("reset gameover", int'(gameover), 0);
        check("reset field_clear", int'(field_clear), 0);
        rst = 1'b0;
        @(negedge clk);

        // Spawn, then the table of moves (finishes before the first gravity tick).
        start_game(1'b0);
        check_pos("spawn", 8, 0, 0);
        for (int i = 0; i < 10; i++) do_move(vecs[i].key, vecs[i].coll, vecs[i].cx, vecs[i].cy,
            vecs[i].cr, vecs[i].px, vecs[i].py, vecs[i].pr, $sformatf("vec%0d", i));

        // Left move, then rotate on the same cycle as the gravity tick.
        do_reset();
        start_game(1'b0);
        do_move(K_LEFT, 1'b0, 7, 0, 0, 7, 0, 0, "left");
        repeat (DROP - 4) @(negedge clk);
        push_cand(7, 0, 1);
        push_cand(7, 1, 1);
        collide_val = 1'b0;
        ro = 1'b1;
        @(negedge clk);
        ro = 1'b0;
        repeat (2) @(negedge clk);
        check_pos("rot before grav", 7, 0, 1);
        repeat (3) @(negedge clk);
        check_pos("grav after rot", 7, 1, 1);

        // Soft drop to the floor, lock, single row clear, then respawn collides.
        do_reset();
        start_game(1'b0);
        for (int i = 0; i < 19; i++) do_move(K_DOWN, 1'b0, 8, i + 1, 0, 8, i + 1, 0, "drop");
        down = 1'b1;
        @(negedge clk);
        down = 1'b0;
        check("floor no check_req", int'(check_req), 0);
        @(negedge clk);
        check("bg_refresh", int'(bg_refresh), 1);
        row_full[19] = 1'b1;
        @(negedge clk);
        check("clr_en", int'(clr_en), 1);
        check("clr_row", int'(clr_row), 19);
        check("score_plus", int'(score_plus), 1);
        check("lines", int'(lines), 1);
        row_full[19] = 1'b0;
        push_cand(8, 0, 0);
        collide_val = 1'b1;
        begin
            int n = 0;
            while (n < 60 && next_block !== 1'b1) begin
                @(negedge clk);
                n++;
            end
            check("cycles scan to next_block", n, 21);
        end
        repeat (2) @(negedge clk);
        check("gameover", int'(gameover), 1);
        check_pos("over hold", 8, 19, 0);
        check("over lines hold", int'(lines), 1);
        left = 1'b1;
        @(negedge clk);
        left = 1'b0;
        @(negedge clk);
        check("over key ignored", int'(check_req), 0);

        // Restart from OVER, walk to the left wall, discard a left at x==0.
        start_game(1'b0);
        check_pos("restart", 8, 0, 0);
        for (int i = 0; i < 8; i++) do_move(K_LEFT, 1'b0, 7 - i, 0, 0, 7 - i, 0, 0, "walk");
        left = 1'b1;
        @(negedge clk);
        left = 1'b0;
        check("wall no check_req", int'(check_req), 0);
        @(negedge clk);
        check("wall pos_x", int'(pos_x), 0);
        do_move(K_RIGHT, 1'b0, 1, 0, 0, 1, 0, 0, "right");

        // Reset in the middle of a move check.
        push_cand(2, 0, 0);
        right = 1'b1;
        @(negedge clk);
        right = 1'b0;
        check("mid check_req", int'(check_req), 1);
        #1 rst = 1'b1;
        #1;
        check_pos("mid rst", 0, 0, 0);
        check("mid rst cand_x", int'(cand_x), 0);
        check("mid rst check_req", int'(check_req), 0);
        check("mid rst gameover", int'(gameover), 0);
        @(negedge clk);
        check("scoreboard drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
